// File: rtl/pim_dma_pkg.sv
// Shared types and constants for the PIM DMA engine.
//   - Widths of the data/address path, PIM word address and bank select.
//   - DMA direction encodings carried on funct3.
//   - FSM state type and the latched command record.
package pim_dma_pkg;

    localparam int unsigned XLEN   = 32;  // data/address width
    localparam int unsigned PIM_AW = 11;  // PIM word-address width
    localparam int unsigned N_PIM  = 4;   // number of PIM banks

    localparam logic [2:0] DMA_MEM2PIM = 3'b000;
    localparam logic [2:0] DMA_PIM2MEM = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain,
        StDone
    } dma_state_e;

    typedef struct packed {
        logic [2:0]        funct3;
        logic [N_PIM-1:0]  sel;
        logic [XLEN-1:0]   addr;
        logic [PIM_AW-1:0] nwords;
    } dma_cmd_t;

    function automatic logic is_onehot(input logic [N_PIM-1:0] v);
        return (v != '0) && ((v & (v - N_PIM'(1))) == '0);
    endfunction

endpackage

// File: rtl/pim_dma_fifo.sv
// Two-entry skid FIFO holding PIM read data until the dmem port accepts it.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push/i_wdata : write one entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_rdata        : head entry
//   o_full/o_empty : occupancy flags
//   o_count        : number of entries held (0..2)
module pim_dma_fifo
    import pim_dma_pkg::*;
#(
    parameter int unsigned Width = XLEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [Width-1:0] mem_q [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= i_wdata;
                wptr_q        <= !wptr_q;
            end
            if (do_pop) begin
                rptr_q <= !rptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_rdata = mem_q[rptr_q];
    assign o_full  = (count_q == 2'd2);
    assign o_empty = (count_q == 2'd0);
    assign o_count = count_q;

endmodule

// File: rtl/pim_dma.sv
// Word-streaming DMA between data memory and PIM banks, fed by the core's EX-stage
// DMA command strobe. Holds o_dma_busy from the cycle after acceptance until the
// last word has landed.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_dma_*                 : command strobe, direction, bank select, size, start address
//   o_dma_busy, o_dma_err   : transfer in progress, sticky error (cleared by next command)
//   o_req_dmem, i_gnt_dmem  : dmem port arbitration
//   o_mem_*, i_mem_rd_data  : dmem port (read data one cycle after an accepted read)
//   o_pim_*, i_pim_rd_data  : PIM port (read data one cycle after o_pim_read)
module pim_dma
    import pim_dma_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dma_en,
    input  logic [2:0]        i_dma_funct3,
    input  logic [N_PIM-1:0]  i_dma_sel_pim,
    input  logic [12:0]       i_dma_size,
    input  logic [XLEN-1:0]   i_dma_mem_addr,
    output logic              o_dma_busy,
    output logic              o_dma_err,
    output logic              o_req_dmem,
    input  logic              i_gnt_dmem,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [3:0]        o_mem_size,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [XLEN-1:0]   i_mem_rd_data,
    output logic [N_PIM-1:0]  o_pim_sel,
    output logic [PIM_AW-1:0] o_pim_addr,
    output logic [XLEN-1:0]   o_pim_wr_data,
    output logic              o_pim_write,
    output logic              o_pim_read,
    input  logic [XLEN-1:0]   i_pim_rd_data
);

    dma_state_e        state_q;
    dma_cmd_t          cmd_q;       // cmd_q.addr advances as the running memory address
    logic [PIM_AW-1:0] issue_q;     // beats issued on the source side
    logic [PIM_AW-1:0] cmpl_q;      // beats landed on the destination side
    logic              busy_q;
    logic              err_q;
    logic              mrd_pend_q;  // memory read accepted last cycle, data on i_mem_rd_data
    logic              prd_pend_q;  // PIM read issued last cycle, data on i_pim_rd_data

    logic [XLEN-1:0]   fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              fifo_push;
    logic              fifo_pop;

    logic              is_m2p;
    logic              in_xfer;
    logic              in_active;
    logic              issue_left;
    logic [1:0]        fifo_free;
    logic              fifo_room;
    logic              mem_rd_go;
    logic              mem_wr_go;
    logic              pim_rd_go;
    logic              pim_wr_go;
    logic              drained;
    logic              cmd_bad;
    logic [PIM_AW-1:0] cmd_nwords;

    always_comb begin
        is_m2p     = (cmd_q.funct3 == DMA_MEM2PIM);
        in_xfer    = (state_q == StXfer);
        in_active  = in_xfer || (state_q == StDrain);
        issue_left = (issue_q != cmd_q.nwords);
        // A PIM read only goes out if its return already has a FIFO slot reserved,
        // so a push can never meet a full FIFO.
        fifo_free  = 2'd2 - fifo_count;
        fifo_room  = (fifo_free > {1'b0, prd_pend_q});
        mem_rd_go  = in_xfer && is_m2p && issue_left && i_gnt_dmem;
        mem_wr_go  = in_active && !is_m2p && !fifo_empty && i_gnt_dmem;
        pim_rd_go  = in_xfer && !is_m2p && issue_left && fifo_room;
        pim_wr_go  = mrd_pend_q;
        drained    = (cmpl_q == cmd_q.nwords) && !mrd_pend_q && !prd_pend_q;
        cmd_nwords = i_dma_size[12:2];
        cmd_bad    = !((i_dma_funct3 == DMA_MEM2PIM) ||
                       ((i_dma_funct3 == DMA_PIM2MEM) && is_onehot(i_dma_sel_pim)));
    end

    assign fifo_push = prd_pend_q;
    assign fifo_pop  = mem_wr_go;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            issue_q    <= '0;
            cmpl_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            mrd_pend_q <= 1'b0;
            prd_pend_q <= 1'b0;
        end else begin
            mrd_pend_q <= mem_rd_go;
            prd_pend_q <= pim_rd_go;
            if (mem_rd_go || pim_rd_go) begin
                issue_q <= issue_q + PIM_AW'(1);
            end
            if (pim_wr_go || mem_wr_go) begin
                cmpl_q <= cmpl_q + PIM_AW'(1);
            end
            if (mem_rd_go || mem_wr_go) begin
                cmd_q.addr <= cmd_q.addr + XLEN'(4);
            end
            unique case (state_q)
                StIdle: begin
                    if (i_dma_en) begin
                        cmd_q.funct3 <= i_dma_funct3;
                        cmd_q.sel    <= cmd_bad ? '0 : i_dma_sel_pim;
                        cmd_q.addr   <= {i_dma_mem_addr[XLEN-1:2], 2'b00};
                        cmd_q.nwords <= cmd_nwords;
                        issue_q      <= '0;
                        cmpl_q       <= '0;
                        err_q        <= cmd_bad;
                        busy_q       <= 1'b1;
                        state_q      <= (cmd_bad || (cmd_nwords == '0)) ? StDone : StXfer;
                    end
                end
                StXfer: begin
                    if (!issue_left) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pim_dma_fifo #(
        .Width (XLEN)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_wdata (i_pim_rd_data),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign o_dma_busy    = busy_q;
    assign o_dma_err     = err_q;
    // PIM->MEM keeps requesting through DRAIN so the FIFO tail can still be written.
    assign o_req_dmem    = in_xfer || ((state_q == StDrain) && !is_m2p);
    assign o_mem_read    = mem_rd_go;
    assign o_mem_write   = mem_wr_go;
    assign o_mem_addr    = (mem_rd_go || mem_wr_go) ? cmd_q.addr : '0;
    assign o_mem_wr_data = mem_wr_go ? fifo_rdata : '0;
    assign o_mem_size    = (mem_rd_go || mem_wr_go) ? 4'b1111 : 4'b0000;
    assign o_pim_sel     = (state_q != StIdle) ? cmd_q.sel : '0;
    assign o_pim_read    = pim_rd_go;
    assign o_pim_write   = pim_wr_go;
    assign o_pim_addr    = pim_rd_go ? issue_q : (pim_wr_go ? cmpl_q : '0);
    assign o_pim_wr_data = pim_wr_go ? i_mem_rd_data : '0;

    logic unused_bits;
    assign unused_bits = ^{fifo_full, i_dma_size[1:0], i_dma_mem_addr[1:0]};

endmodule

// File: tb/tb_pim_dma.sv
module tb_pim_dma;
    import pim_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dma_en = 1'b0;
    logic [2:0]  dma_funct3 = 3'b000;
    logic [3:0]  dma_sel = 4'b0000;
    logic [12:0] dma_size = 13'd0;
    logic [31:0] dma_addr = 32'h0;
    logic        dma_busy, dma_err, req_dmem;
    logic        gnt = 1'b1;
    logic [31:0] mem_addr, mem_wr_data;
    logic [3:0]  mem_size;
    logic        mem_read, mem_write;
    logic [31:0] mem_rd_data = 32'h0;
    logic [3:0]  pim_sel;
    logic [10:0] pim_addr;
    logic [31:0] pim_wr_data;
    logic        pim_write, pim_read;
    logic [31:0] pim_rd_data = 32'h0;

    int total = 0;
    int bad = 0;

    pim_dma u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_dma_en       (dma_en),
        .i_dma_funct3   (dma_funct3),
        .i_dma_sel_pim  (dma_sel),
        .i_dma_size     (dma_size),
        .i_dma_mem_addr (dma_addr),
        .o_dma_busy     (dma_busy),
        .o_dma_err      (dma_err),
        .o_req_dmem     (req_dmem),
        .i_gnt_dmem     (gnt),
        .o_mem_addr     (mem_addr),
        .o_mem_wr_data  (mem_wr_data),
        .o_mem_size     (mem_size),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .i_mem_rd_data  (mem_rd_data),
        .o_pim_sel      (pim_sel),
        .o_pim_addr     (pim_addr),
        .o_pim_wr_data  (pim_wr_data),
        .o_pim_write    (pim_write),
        .o_pim_read     (pim_read),
        .i_pim_rd_data  (pim_rd_data)
    );

    always #5 clk = ~clk;

    // Memory returns {~addr[31:16], addr[15:0]}; PIM returns 0xC0DE_0000 | word address.
    always @(posedge clk) begin
        mem_rd_data <= (mem_read && gnt) ? {~mem_addr[31:16], mem_addr[15:0]} : 32'h0;
        pim_rd_data <= pim_read ? (32'hC0DE_0000 | 32'(pim_addr)) : 32'h0;
    end

    logic any_out;
    assign any_out = |{dma_busy, dma_err, req_dmem, mem_addr, mem_wr_data, mem_size, mem_read,
                       mem_write, pim_sel, pim_addr, pim_wr_data, pim_write, pim_read};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got beat 0x%0h expected no beat", nm, act);
    endtask

    // Scoreboard queues: addresses for reads, {addr, data} for writes.
    logic [31:0] exp_mrd[$];
    logic [31:0] exp_prd[$];
    logic [63:0] exp_pwr[$];
    logic [63:0] exp_mwr[$];
    logic [3:0]  exp_sel = 4'b0000;
    int          pwr_seen = 0;
    bit          sb_off = 1'b0;
    logic [63:0] e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pim_write) pwr_seen++;
            if (!sb_off) begin
                if (mem_read || mem_write) chk("mem_gnt", 64'(gnt), 64'd1);
                if (mem_read && gnt) begin
                    if (exp_mrd.size() == 0) unexp("mem_rd", 64'(mem_addr));
                    else begin
                        e = 64'(exp_mrd.pop_front());
                        chk("mem_rd_addr", 64'(mem_addr), e);
                        chk("mem_rd_size", 64'(mem_size), 64'hF);
                    end
                end
                if (mem_write) begin
                    if (exp_mwr.size() == 0) unexp("mem_wr", {mem_addr, mem_wr_data});
                    else begin
                        e = exp_mwr.pop_front();
                        chk("mem_wr_addr", 64'(mem_addr), 64'(e[63:32]));
                        chk("mem_wr_data", 64'(mem_wr_data), 64'(e[31:0]));
                        chk("mem_wr_size", 64'(mem_size), 64'hF);
                    end
                end
                if (pim_read) begin
                    if (exp_prd.size() == 0) unexp("pim_rd", 64'(pim_addr));
                    else begin
                        e = 64'(exp_prd.pop_front());
                        chk("pim_rd_addr", 64'(pim_addr), e);
                        chk("pim_rd_sel", 64'(pim_sel), 64'(exp_sel));
                    end
                end
                if (pim_write) begin
                    if (exp_pwr.size() == 0) unexp("pim_wr", {21'd0, pim_addr, pim_wr_data});
                    else begin
                        e = exp_pwr.pop_front();
                        chk("pim_wr_addr", 64'(pim_addr), 64'(e[63:32]));
                        chk("pim_wr_data", 64'(pim_wr_data), 64'(e[31:0]));
                        chk("pim_wr_sel", 64'(pim_sel), 64'(exp_sel));
                    end
                end
            end
        end
    end

    task automatic exp_m2p(input logic [31:0] a, input logic [10:0] pa, input logic [31:0] d);
        exp_mrd.push_back(a);
        exp_pwr.push_back({21'd0, pa, d});
    endtask

    task automatic exp_p2m(input logic [10:0] pa, input logic [31:0] a, input logic [31:0] d);
        exp_prd.push_back(32'(pa));
        exp_mwr.push_back({a, d});
    endtask

    // Issue one command, drive grant per gmask (bit k = grant low in cycle k after acceptance),
    // optionally re-pulse dma_en in cycle pulse_at, and count busy cycles until busy drops.
    task automatic run_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                           input logic [31:0] addr, input logic [15:0] gmask, input int pulse_at,
                           output int busy_n);
        bit timed_out = 1'b1;
        @(posedge clk); #1;
        dma_en = 1'b1; dma_funct3 = f3; dma_sel = sel; dma_size = size; dma_addr = addr;
        gnt = 1'b1;
        @(posedge clk); #1;
        dma_en = 1'b0;
        busy_n = 0;
        for (int k = 1; k < 200; k++) begin
            gnt = (k < 16) ? !gmask[k[3:0]] : 1'b1;
            if (k == pulse_at) begin
                dma_en = 1'b1; dma_funct3 = DMA_PIM2MEM; dma_sel = 4'b0001;
                dma_size = 13'd64; dma_addr = 32'h4000_0000;
            end else begin
                dma_en = 1'b0;
            end
            @(negedge clk);
            if (!dma_busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_n++;
            @(posedge clk); #1;
        end
        gnt = 1'b1;
        dma_en = 1'b0;
        if (timed_out) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0d after 200 cycles expected 0", dma_busy);
        end
        #1;
    endtask

    task automatic end_check(input string nm, input int busy_n, input int exp_busy,
                             input logic exp_err);
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        chk({nm, "_err"}, 64'(dma_err), 64'(exp_err));
        chk({nm, "_left_mrd"}, 64'(exp_mrd.size()), 64'd0);
        chk({nm, "_left_mwr"}, 64'(exp_mwr.size()), 64'd0);
        chk({nm, "_left_prd"}, 64'(exp_prd.size()), 64'd0);
        chk({nm, "_left_pwr"}, 64'(exp_pwr.size()), 64'd0);
        exp_mrd.delete(); exp_mwr.delete(); exp_prd.delete(); exp_pwr.delete();
    endtask

    int  nb;
    bit  reached;

    initial begin
        #12;
        chk("reset_outputs", 64'(any_out), 64'd0);
        chk("reset_busy", 64'(dma_busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MEM->PIM, 4 words, grant always high
        exp_sel = 4'b0010;
        exp_m2p(32'h2000_0010, 11'd0, 32'hDFFF_0010);
        exp_m2p(32'h2000_0014, 11'd1, 32'hDFFF_0014);
        exp_m2p(32'h2000_0018, 11'd2, 32'hDFFF_0018);
        exp_m2p(32'h2000_001C, 11'd3, 32'hDFFF_001C);
        run_cmd(DMA_MEM2PIM, 4'b0010, 13'd16, 32'h2000_0010, 16'h0000, -1, nb);
        end_check("m2p4", nb, 7, 1'b0);
        chk("idle_outputs", 64'(any_out), 64'd0);

        // PIM->MEM, 3 words, grant low in cycles 2..4
        exp_sel = 4'b0001;
        exp_p2m(11'd0, 32'h1000_0100, 32'hC0DE_0000);
        exp_p2m(11'd1, 32'h1000_0104, 32'hC0DE_0001);
        exp_p2m(11'd2, 32'h1000_0108, 32'hC0DE_0002);
        run_cmd(DMA_PIM2MEM, 4'b0001, 13'd12, 32'h1000_0100, 16'b0000_0000_0001_1100, -1, nb);
        end_check("p2m3_gnt", nb, 10, 1'b0);

        // Zero length
        run_cmd(DMA_MEM2PIM, 4'b0010, 13'd3, 32'h5000_0000, 16'h0000, -1, nb);
        end_check("zero_len", nb, 1, 1'b0);

        // Illegal funct3, then PIM->MEM with non-one-hot select
        run_cmd(3'b101, 4'b0001, 13'd16, 32'h5000_0000, 16'h0000, -1, nb);
        end_check("bad_f3", nb, 1, 1'b1);
        run_cmd(DMA_PIM2MEM, 4'b0011, 13'd16, 32'h5000_0000, 16'h0000, -1, nb);
        end_check("bad_sel", nb, 1, 1'b1);

        // Next legal command clears the error; low address bits forced to 0
        exp_sel = 4'b0001;
        exp_m2p(32'h6000_0008, 11'd0, 32'h9FFF_0008);
        run_cmd(DMA_MEM2PIM, 4'b0001, 13'd4, 32'h6000_000B, 16'h0000, -1, nb);
        end_check("err_clear", nb, 4, 1'b0);

        // Memory address wraps past 0xFFFF_FFFC
        exp_sel = 4'b1000;
        exp_m2p(32'hFFFF_FFF8, 11'd0, 32'h0000_FFF8);
        exp_m2p(32'hFFFF_FFFC, 11'd1, 32'h0000_FFFC);
        exp_m2p(32'h0000_0000, 11'd2, 32'hFFFF_0000);
        exp_m2p(32'h0000_0004, 11'd3, 32'hFFFF_0004);
        run_cmd(DMA_MEM2PIM, 4'b1000, 13'd16, 32'hFFFF_FFF9, 16'h0000, -1, nb);
        end_check("wrap", nb, 7, 1'b0);

        // dma_en re-pulsed mid-transfer is ignored
        exp_sel = 4'b0100;
        exp_m2p(32'h3000_0000, 11'd0, 32'hCFFF_0000);
        exp_m2p(32'h3000_0004, 11'd1, 32'hCFFF_0004);
        exp_m2p(32'h3000_0008, 11'd2, 32'hCFFF_0008);
        exp_m2p(32'h3000_000C, 11'd3, 32'hCFFF_000C);
        exp_m2p(32'h3000_0010, 11'd4, 32'hCFFF_0010);
        run_cmd(DMA_MEM2PIM, 4'b0100, 13'd20, 32'h3000_0000, 16'h0000, 2, nb);
        end_check("repulse", nb, 8, 1'b0);

        // Reset after 2 of 8 words
        sb_off = 1'b1;
        pwr_seen = 0;
        reached = 1'b0;
        @(posedge clk); #1;
        dma_en = 1'b1; dma_funct3 = DMA_MEM2PIM; dma_sel = 4'b0010;
        dma_size = 13'd32; dma_addr = 32'h0000_0100;
        @(posedge clk); #1;
        dma_en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (pwr_seen >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) begin
            total++;
            bad++;
            $display("FAIL rst_progress: got %0d pim writes expected 2", pwr_seen);
        end
        chk("pre_rst_busy", 64'(dma_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 64'(any_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_off = 1'b0;

        // Fresh 4-word PIM->MEM after the reset
        exp_sel = 4'b1000;
        exp_p2m(11'd0, 32'h0000_0040, 32'hC0DE_0000);
        exp_p2m(11'd1, 32'h0000_0044, 32'hC0DE_0001);
        exp_p2m(11'd2, 32'h0000_0048, 32'hC0DE_0002);
        exp_p2m(11'd3, 32'h0000_004C, 32'hC0DE_0003);
        run_cmd(DMA_PIM2MEM, 4'b1000, 13'd16, 32'h0000_0040, 16'h0000, -1, nb);
        end_check("post_rst", nb, 9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
